dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder: the slave end of the dmem request interface driven by the pipeline memory stage. It accepts one word-aligned read or write per request, applies the 32-bit write-keep mask on stores, returns registered read data, and models configurable access latency through a busy/done handshake. The memory stage uses `busy_o` as its stall source.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- LATENCY, 1: cycles from request accept to commit; must be at least 1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
- addr_i  in  WD_SIZE  byte address; bits [1:0] ignored.
- rd_wr_i  in  1  1 = write, 0 = read.
- op_en_i  in  1  request valid.
- wr_data_i  in  WD_SIZE  store data, already lane-shifted by the requester.
- wr_keep_i  in  WD_SIZE  per-bit write mask: 1 = update the bit.
- rd_data_o  out  WD_SIZE  full aligned word from the last completed read.
- busy_o  out  1  request in flight; new requests are not accepted.
- done_o  out  1  one-cycle pulse when a request commits.
- err_o  out  1  out-of-range pulse, coincident with done_o.

## Operation
- FSM states:
  - IDLE
  - BUSY, counter cnt of width $clog2(LATENCY)+1
  - DONE, one cycle
- IDLE with op_en_i=1: latch addr, rd_wr, wr_data and wr_keep.
  - LATENCY=1: commit at this edge, then go to DONE.
  - Otherwise: go to BUSY with cnt=LATENCY-1.
- BUSY: decrement cnt each cycle. In the cycle cnt==1, commit at the clock edge and go to DONE.
- DONE: return to IDLE. A request is accepted in DONE exactly as in IDLE, giving back-to-back throughput for LATENCY=1.
- Commit for a write: mem[idx] <= (mem[idx] & ~keep) | (wr_data & keep). rd_data_o is unchanged.
- Commit for a read: rd_data_o <= mem[idx]. It holds until the next read commits.
- idx = addr[$clog2(DEPTH_WORDS)+1:2].
- op_en_i in BUSY is ignored. The requester must hold the request until it sees busy_o low.
- wr_keep_i = 0 on a write: no bits change, but done_o still pulses.
- Read-after-write to the same word in consecutive requests returns the newly written data.

## Timing
- Reset values:
  - state IDLE
  - rd_data_o 0
  - busy_o 0, done_o 0, err_o 0
  - memory contents not reset
- All outputs are registered. There is no combinational path from op_en_i to busy_o.
- busy_o is 1 exactly while the state is BUSY: the LATENCY-1 cycles following accept.
- done_o is 1 in the cycle after commit, which is LATENCY cycles after the accept cycle.
- rd_data_o is valid from the done_o cycle onward.
- Reset asserted mid-request aborts it: a pending write is discarded and no done_o pulse is produced.

## Configuration
- DMEM_BOUNDS_CHECK_EN defined:
  - Any address bit above $clog2(DEPTH_WORDS)+1 set makes the request out of range.
  - An out-of-range write is dropped.
  - An out-of-range read loads DMEM_ERR_PATTERN (32'hDEADBEEF) into rd_data_o.
  - err_o pulses together with done_o.
- DMEM_BOUNDS_CHECK_EN undefined:
  - Upper address bits are ignored, so addresses alias and wrap.
  - err_o is tied to 0.

## Structure
- PARAMS_pkg gains:
  - dmem_state_t enum {DMEM_IDLE, DMEM_BUSY, DMEM_DONE}
  - DMEM_ERR_PATTERN
- WD_SIZE comes from PARAMS_pkg.
- Sub-module dmem_array holds the storage, the keep-masked write port and the synchronous read port. dmem_responder holds the FSM, counter, request latches and bounds logic.

## Test plan
- LATENCY=1:
  - Write 0x11223344 with keep 0xFFFFFFFF to addr 0x10, then read 0x10.
  - Expect done_o one cycle after each accept, busy_o never high, rd_data_o=0x11223344.
- Byte store:
  - Write 0x0000AB00 with keep 0x0000FF00 to addr 0x11 over word 0x11223344, then read 0x10.
  - Expect rd_data_o=0x1122AB44.
- LATENCY=4:
  - Issue a read.
  - Expect busy_o high for exactly 3 cycles and done_o in cycle 4.
  - A second op_en_i during busy is ignored, with no extra done_o.
- Reset mid-operation, LATENCY=4:
  - Write, then assert reset_n=0 in the second busy cycle.
  - Expect busy_o=0, no done_o, word unchanged on a later read, rd_data_o=0.
- With DMEM_BOUNDS_CHECK_EN and DEPTH_WORDS=1024:
  - Read addr 0x1000: expect rd_data_o=0xDEADBEEF and err_o pulse with done_o.
  - Write addr 0x1000: expect word 0 unchanged.
- Without the macro:
  - Write addr 0x1000, then read addr 0x0: expect the written data (aliasing) and err_o=0.

Source files
------------

// File: rtl/PARAMS_pkg.sv
// rtl/PARAMS_pkg.sv - shared word size, dmem FSM state type and error pattern
//
// Contents:
//   WD_SIZE           data/address word width in bits
//   DMEM_ERR_PATTERN  word returned by an out-of-range read (bounds-checked builds)
//   dmem_state_t      dmem responder FSM states
package PARAMS_pkg;

  localparam int WD_SIZE = 32;

  localparam logic [WD_SIZE-1:0] DMEM_ERR_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with keep-masked write port and registered read port
//
// Ports:
//   clk      in   clock
//   reset_n  in   synchronous active-low reset (read register only; storage is not reset)
//   wr_en    in   commit a masked write to word idx
//   rd_en    in   load the read register
//   rd_err   in   with rd_en: load DMEM_ERR_PATTERN instead of the stored word
//   idx      in   word index
//   wr_data  in   store data
//   wr_keep  in   per-bit write mask, 1 = update the bit
//   rd_data  out  read register, holds until the next rd_en
module dmem_array
  import PARAMS_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic                           rd_err,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WD_SIZE-1:0]             wr_data,
  input  logic [WD_SIZE-1:0]             wr_keep,
  output logic [WD_SIZE-1:0]             rd_data
);

  logic [WD_SIZE-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= (mem[idx] & ~wr_keep) | (wr_data & wr_keep);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_err ? DMEM_ERR_PATTERN : mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dmem request slave: latency FSM, request latches, bounds logic
//
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag addresses beyond DEPTH_WORDS
// (dropped writes, DMEM_ERR_PATTERN reads, err_o pulse). Without it upper address
// bits alias and err_o is tied low.
//
// Ports:
//   clk        in   clock
//   reset_n    in   synchronous active-low reset
//   addr_i     in   byte address, bits [1:0] ignored
//   rd_wr_i    in   1 = write, 0 = read
//   op_en_i    in   request valid
//   wr_data_i  in   store data, lane-shifted by the requester
//   wr_keep_i  in   per-bit write mask
//   rd_data_o  out  word from the last completed read
//   busy_o     out  request in flight, new requests not accepted
//   done_o     out  one-cycle commit pulse
//   err_o      out  out-of-range pulse, coincident with done_o
module dmem_responder
  import PARAMS_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WD_SIZE-1:0] addr_i,
  input  logic               rd_wr_i,
  input  logic               op_en_i,
  input  logic [WD_SIZE-1:0] wr_data_i,
  input  logic [WD_SIZE-1:0] wr_keep_i,
  output logic [WD_SIZE-1:0] rd_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam bit FAST  = (LATENCY == 1);

  localparam logic [1:0] ST_IDLE = DMEM_IDLE;
  localparam logic [1:0] ST_BUSY = DMEM_BUSY;
  localparam logic [1:0] ST_DONE = DMEM_DONE;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;

  logic [IDX_W-1:0]   idx_q;
  logic               rd_wr_q;
  logic               oor_q;
  logic [WD_SIZE-1:0] wr_data_q;
  logic [WD_SIZE-1:0] wr_keep_q;

  logic               accept;
  logic               req_oor;
  logic               commit;
  logic [IDX_W-1:0]   c_idx;
  logic               c_wr;
  logic               c_oor;
  logic [WD_SIZE-1:0] c_data;
  logic [WD_SIZE-1:0] c_keep;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[1:0], addr_i[WD_SIZE-1:IDX_W+2]};

`ifdef DMEM_BOUNDS_CHECK_EN
  assign req_oor = |addr_i[WD_SIZE-1:IDX_W+2];
`else
  assign req_oor = 1'b0;
`endif

  // DONE accepts like IDLE so LATENCY=1 sustains one request per cycle.
  assign accept = op_en_i && ((state == ST_IDLE) || (state == ST_DONE));

  // LATENCY=1 commits on the accept edge straight from the inputs; longer
  // latencies commit from the latched request on the last BUSY edge.
  assign commit = FAST ? accept : ((state == ST_BUSY) && (cnt == CNT_W'(1)));
  assign c_idx  = FAST ? addr_i[IDX_W+1:2] : idx_q;
  assign c_wr   = FAST ? rd_wr_i           : rd_wr_q;
  assign c_oor  = FAST ? req_oor           : oor_q;
  assign c_data = FAST ? wr_data_i         : wr_data_q;
  assign c_keep = FAST ? wr_keep_i         : wr_keep_q;

  // Gating with reset_n makes a reset on the commit edge discard the write.
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (commit && c_wr && !c_oor && reset_n),
    .rd_en   (commit && !c_wr && reset_n),
    .rd_err  (c_oor),
    .idx     (c_idx),
    .wr_data (c_data),
    .wr_keep (c_keep),
    .rd_data (rd_data_o)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q     <= addr_i[IDX_W+1:2];
      rd_wr_q   <= rd_wr_i;
      oor_q     <= req_oor;
      wr_data_q <= wr_data_i;
      wr_keep_q <= wr_keep_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (FAST) begin
              state <= ST_DONE;
            end else begin
              state <= ST_BUSY;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state == ST_BUSY);
  assign done_o = (state == ST_DONE);

`ifdef DMEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_o <= 1'b0;
    end else begin
      err_o <= commit && c_oor;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 1 and 4
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rw1, en1, busy1, done1, err1;
  logic [31:0] addr1, wd1, wk1, rd1;
  logic        rst4, rw4, en4, busy4, done4, err4;
  logic [31:0] addr4, wd4, wk4, rd4;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(rst1), .addr_i(addr1), .rd_wr_i(rw1), .op_en_i(en1),
    .wr_data_i(wd1), .wr_keep_i(wk1), .rd_data_o(rd1), .busy_o(busy1),
    .done_o(done1), .err_o(err1)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset_n(rst4), .addr_i(addr4), .rd_wr_i(rw4), .op_en_i(en4),
    .wr_data_i(wd4), .wr_keep_i(wk4), .rd_data_o(rd4), .busy_o(busy4),
    .done_o(done4), .err_o(err4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model for the LATENCY=1 instance: the first 16 words and the
  // word the responder should be presenting on rd_data_o.
  logic [31:0] m1 [16];
  logic [31:0] exp_rd1;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] keep;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request on instance w (1 or 4) and observe it to completion.
  task automatic req(input int w, input logic [31:0] a, input logic rw,
                     input logic [31:0] d, input logic [31:0] k,
                     output int done_cyc, output int busy_cyc,
                     output logic err, output logic [31:0] rd);
    @(negedge clk);
    if (w == 1) begin
      addr1 = a; rw1 = rw; wd1 = d; wk1 = k; en1 = 1'b1;
    end else begin
      addr4 = a; rw4 = rw; wd4 = d; wk4 = k; en4 = 1'b1;
    end
    done_cyc = -1; busy_cyc = 0; err = 1'b0; rd = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        en1 = 1'b0; en4 = 1'b0;
      end
      if (w == 1) begin
        if (busy1) busy_cyc++;
        if (done1) begin done_cyc = c; err = err1; rd = rd1; break; end
      end else begin
        if (busy4) busy_cyc++;
        if (done4) begin done_cyc = c; err = err4; rd = rd4; break; end
      end
    end
  endtask

  // LATENCY=1 request checked against the model.
  task automatic op1(input string name, input logic [31:0] a, input logic rw,
                     input logic [31:0] d, input logic [31:0] k);
    int dc, bc;
    logic e;
    logic [31:0] r;
    int idx;
    req(1, a, rw, d, k, dc, bc, e, r);
    idx = int'(a[5:2]);
    if (rw) m1[idx] = (m1[idx] & ~k) | (d & k);
    else    exp_rd1 = m1[idx];
    check({name, " done_cycle"}, 32'(dc), 32'd1);
    check({name, " busy_cycles"}, 32'(bc), 32'd0);
    check({name, " err"}, {31'd0, e}, 32'd0);
    check({name, " rd_data"}, r, exp_rd1);
  endtask

  initial begin
    int dc, bc, busy_n, done_n, first_done;
    logic e;
    logic [31:0] r, a, d, k, rd_at_done;

    rst1 = 0; rw1 = 0; en1 = 0; addr1 = 0; wd1 = 0; wk1 = 0;
    rst4 = 0; rw4 = 0; en4 = 0; addr4 = 0; wd4 = 0; wk4 = 0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    exp_rd1 = '0;

    vecs[0] = '{1'b1, 32'h10, 32'h11223344, 32'hFFFFFFFF, 32'h00000000};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        32'h0,        32'h11223344};
    vecs[2] = '{1'b1, 32'h11, 32'h0000AB00, 32'h0000FF00, 32'h11223344};
    vecs[3] = '{1'b0, 32'h10, 32'h0,        32'h0,        32'h1122AB44};
    vecs[4] = '{1'b1, 32'h12, 32'hFFFFFFFF, 32'h00000000, 32'h1122AB44};
    vecs[5] = '{1'b0, 32'h13, 32'h0,        32'h0,        32'h1122AB44};
    vecs[6] = '{1'b1, 32'h14, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h1122AB44};
    vecs[7] = '{1'b0, 32'h14, 32'h0,        32'h0,        32'hCAFEF00D};

    repeat (3) @(negedge clk);
    check("reset rd_data l1", rd1, 32'h0);
    check("reset busy l1", {31'd0, busy1}, 32'd0);
    check("reset done l1", {31'd0, done1}, 32'd0);
    check("reset err l1", {31'd0, err1}, 32'd0);
    check("reset rd_data l4", rd4, 32'h0);
    check("reset busy l4", {31'd0, busy4}, 32'd0);
    check("reset done l4", {31'd0, done4}, 32'd0);
    rst1 = 1; rst4 = 1;

    // Table vectors with fixed expectations from the test plan.
    for (int i = 0; i < 8; i++) begin
      req(1, vecs[i].addr, vecs[i].rw, vecs[i].data, vecs[i].keep, dc, bc, e, r);
      check($sformatf("vec%0d done_cycle", i), 32'(dc), 32'd1);
      check($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'd0);
      check($sformatf("vec%0d rd_data", i), r, vecs[i].exp_rd);
      if (vecs[i].rw) begin
        m1[vecs[i].addr[5:2]] = (m1[vecs[i].addr[5:2]] & ~vecs[i].keep) | (vecs[i].data & vecs[i].keep);
      end else begin
        m1[vecs[i].addr[5:2]] = vecs[i].exp_rd;
      end
      exp_rd1 = vecs[i].exp_rd;
    end
    exp_rd1 = 32'hCAFEF00D;

    // Back-to-back write then read of the same word, accepted in DONE.
    @(negedge clk);
    addr1 = 32'h20; rw1 = 1; wd1 = 32'h600DCAFE; wk1 = 32'hFFFFFFFF; en1 = 1;
    @(negedge clk);
    check("b2b write done", {31'd0, done1}, 32'd1);
    check("b2b write busy", {31'd0, busy1}, 32'd0);
    rw1 = 0;
    @(negedge clk);
    check("b2b read done", {31'd0, done1}, 32'd1);
    check("b2b read rd_data", rd1, 32'h600DCAFE);
    en1 = 0;
    @(negedge clk);
    check("b2b idle done", {31'd0, done1}, 32'd0);
    m1[8] = 32'h600DCAFE;
    exp_rd1 = 32'h600DCAFE;

    // Fill the model region, then random traffic.
    for (int i = 0; i < 16; i++) op1("fill", 32'(i * 4), 1'b1, $urandom, 32'hFFFFFFFF);
    for (int i = 0; i < 150; i++) begin
      a = {26'd0, 6'($urandom_range(0, 63))};
      d = $urandom;
      case ($urandom_range(0, 3))
        0: k = 32'hFFFFFFFF;
        1: k = 32'hFF << (8 * a[1:0]);
        2: k = $urandom;
        default: k = 32'h0;
      endcase
      op1($sformatf("rand%0d", i), a, 1'($urandom_range(0, 1)), d, k);
    end

    // Address beyond DEPTH_WORDS on the 1024-word instance.
    op1("bounds pre-write", 32'h0, 1'b1, 32'h12345678, 32'hFFFFFFFF);
`ifdef DMEM_BOUNDS_CHECK_EN
    req(1, 32'h1000, 1'b0, 32'h0, 32'h0, dc, bc, e, r);
    check("oor read done_cycle", 32'(dc), 32'd1);
    check("oor read rd_data", r, 32'hDEADBEEF);
    check("oor read err", {31'd0, e}, 32'd1);
    exp_rd1 = 32'hDEADBEEF;
    req(1, 32'h1000, 1'b1, 32'hFFFF0000, 32'hFFFFFFFF, dc, bc, e, r);
    check("oor write err", {31'd0, e}, 32'd1);
    op1("oor word0 unchanged", 32'h0, 1'b0, 32'h0, 32'h0);
`else
    req(1, 32'h1000, 1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF, dc, bc, e, r);
    check("alias write done_cycle", 32'(dc), 32'd1);
    check("alias write err", {31'd0, e}, 32'd0);
    m1[0] = 32'hA5A5A5A5;
    op1("alias read word0", 32'h0, 1'b0, 32'h0, 32'h0);
`endif

    // LATENCY=4 timing.
    req(4, 32'h8, 1'b1, 32'h55AA1234, 32'hFFFFFFFF, dc, bc, e, r);
    check("l4 write done_cycle", 32'(dc), 32'd4);
    check("l4 write busy_cycles", 32'(bc), 32'd3);

    // Read with a stray write request raised during busy: must be ignored.
    @(negedge clk);
    addr4 = 32'h8; rw4 = 0; en4 = 1;
    busy_n = 0; done_n = 0; first_done = -1; rd_at_done = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) en4 = 0;
      if (c == 2) begin
        en4 = 1; rw4 = 1; wd4 = 32'hFFFFFFFF; wk4 = 32'hFFFFFFFF;
      end
      if (c == 3) en4 = 0;
      if (busy4) busy_n++;
      if (done4) begin
        done_n++;
        if (first_done < 0) begin first_done = c; rd_at_done = rd4; end
      end
    end
    check("l4 read busy_cycles", 32'(busy_n), 32'd3);
    check("l4 read done_count", 32'(done_n), 32'd1);
    check("l4 read done_cycle", 32'(first_done), 32'd4);
    check("l4 read rd_data", rd_at_done, 32'h55AA1234);
    req(4, 32'h8, 1'b0, 32'h0, 32'h0, dc, bc, e, r);
    check("l4 ignored write rd_data", r, 32'h55AA1234);

    // Reset in the second busy cycle of a write.
    @(negedge clk);
    addr4 = 32'h8; rw4 = 1; wd4 = 32'h0BADF00D; wk4 = 32'hFFFFFFFF; en4 = 1;
    @(negedge clk);
    en4 = 0;
    check("rst-mid busy1", {31'd0, busy4}, 32'd1);
    @(negedge clk);
    rst4 = 0;
    @(negedge clk);
    check("rst-mid busy", {31'd0, busy4}, 32'd0);
    check("rst-mid done", {31'd0, done4}, 32'd0);
    check("rst-mid rd_data", rd4, 32'h0);
    rst4 = 1;
    done_n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done4) done_n++;
    end
    check("rst-mid no done", 32'(done_n), 32'd0);
    req(4, 32'h8, 1'b0, 32'h0, 32'h0, dc, bc, e, r);
    check("rst-mid word unchanged", r, 32'h55AA1234);
    check("rst-mid read done_cycle", 32'(dc), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
